// File: rtl/vend_ctrl.sv
// Vending machine sequencer: coin collection, purchase evaluation through the
// external change datapath, dispense pulse and coin-by-coin change payout.
module vend_ctrl #(
    parameter int PRICE_W    = 7,
    parameter int PRICE_S    = 9,
    parameter int CREDIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic [1:0] sel,
    input  logic       buy,
    input  logic       cancel,
    output logic       coin_reject,
    output logic       buy_fail,
    output logic [3:0] credit,
    output logic       busy,
    output logic       water,
    output logic       soda,
    output logic       coin_out_valid,
    output logic [1:0] coin_out_type,
    input  logic       coin_out_ready,
    output logic [1:0] chg_op1,
    output logic [1:0] chg_op2,
    output logic [3:0] chg_i1,
    output logic [3:0] chg_i2,
    output logic [3:0] chg_i5,
    input  logic [3:0] chg_o1,
    input  logic [3:0] chg_o2,
    input  logic [3:0] chg_o5,
    input  logic       chg_wo,
    input  logic       chg_so
);

    typedef enum logic [1:0] {COLLECT, CALC, VEND, PAYOUT} state_t;

    localparam logic [7:0] PW   = 8'(PRICE_W);
    localparam logic [7:0] PS   = 8'(PRICE_S);
    localparam logic [7:0] CMAX = 8'(CREDIT_MAX);

    state_t     state, state_nx;
    logic [3:0] n1, n2, n5, n1_nx, n2_nx, n5_nx;
    logic [3:0] p1, p2, p5, p1_nx, p2_nx, p5_nx;
    logic [1:0] sel_q, sel_nx;
    logic       wo_q, so_q, wo_nx, so_nx;
    logic       reject_nx, fail_nx;

    logic [7:0] sum, coin_val, price;
    logic [5:0] pcount;
    logic       sel_ok, pay_any;

    assign sum    = {4'd0, n1} + {3'd0, n2, 1'b0} + {2'd0, n5, 2'b0} + {4'd0, n5};
    assign pcount = {2'd0, p1} + {2'd0, p2} + {2'd0, p5};
    assign pay_any = (pcount != 6'd0);
    assign sel_ok = (sel == 2'b01) || (sel == 2'b10);
    assign price  = (sel == 2'b01) ? PW : PS;

    always_comb begin
        case (coin_type)
            2'b01:   coin_val = 8'd1;
            2'b10:   coin_val = 8'd2;
            2'b11:   coin_val = 8'd5;
            default: coin_val = 8'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= COLLECT;
            n1          <= '0;
            n2          <= '0;
            n5          <= '0;
            p1          <= '0;
            p2          <= '0;
            p5          <= '0;
            sel_q       <= '0;
            wo_q        <= 1'b0;
            so_q        <= 1'b0;
            coin_reject <= 1'b0;
            buy_fail    <= 1'b0;
        end else begin
            state       <= state_nx;
            n1          <= n1_nx;
            n2          <= n2_nx;
            n5          <= n5_nx;
            p1          <= p1_nx;
            p2          <= p2_nx;
            p5          <= p5_nx;
            sel_q       <= sel_nx;
            wo_q        <= wo_nx;
            so_q        <= so_nx;
            coin_reject <= reject_nx;
            buy_fail    <= fail_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        n1_nx     = n1;
        n2_nx     = n2;
        n5_nx     = n5;
        p1_nx     = p1;
        p2_nx     = p2;
        p5_nx     = p5;
        sel_nx    = sel_q;
        wo_nx     = wo_q;
        so_nx     = so_q;
        reject_nx = 1'b0;
        fail_nx   = 1'b0;
        case (state)
            COLLECT: begin
                if (cancel) begin
                    // A coin arriving with cancel/buy is refused so the refund
                    // or price check sees a stable credit.
                    reject_nx = coin_valid;
                    if (sum != 8'd0) begin
                        p1_nx    = n1;
                        p2_nx    = n2;
                        p5_nx    = n5;
                        n1_nx    = '0;
                        n2_nx    = '0;
                        n5_nx    = '0;
                        state_nx = PAYOUT;
                    end
                end else if (buy) begin
                    reject_nx = coin_valid;
                    if (!sel_ok || sum < price) begin
                        fail_nx = 1'b1;
                    end else begin
                        sel_nx   = sel;
                        state_nx = CALC;
                    end
                end else if (coin_valid) begin
                    if (coin_val == 8'd0 || (sum + coin_val) > CMAX) begin
                        reject_nx = 1'b1;
                    end else begin
                        case (coin_type)
                            2'b01:   n1_nx = n1 + 4'd1;
                            2'b10:   n2_nx = n2 + 4'd1;
                            default: n5_nx = n5 + 4'd1;
                        endcase
                    end
                end
            end
            CALC: begin
                reject_nx = coin_valid;
                p1_nx     = chg_o1;
                p2_nx     = chg_o2;
                p5_nx     = chg_o5;
                wo_nx     = chg_wo;
                so_nx     = chg_so;
                n1_nx     = '0;
                n2_nx     = '0;
                n5_nx     = '0;
                state_nx  = VEND;
            end
            VEND: begin
                reject_nx = coin_valid;
                state_nx  = PAYOUT;
            end
            default: begin
                reject_nx = coin_valid;
                if (!pay_any) begin
                    sel_nx   = '0;
                    state_nx = COLLECT;
                end else if (coin_out_ready) begin
                    if (p5 != 4'd0)      p5_nx = p5 - 4'd1;
                    else if (p2 != 4'd0) p2_nx = p2 - 4'd1;
                    else                 p1_nx = p1 - 4'd1;
                    // Leave on the last handshake so COLLECT follows immediately.
                    if (pcount == 6'd1) begin
                        sel_nx   = '0;
                        state_nx = COLLECT;
                    end
                end
            end
        endcase
    end

    assign credit         = sum[3:0];
    assign busy           = (state != COLLECT);
    assign water          = (state == VEND) && wo_q;
    assign soda           = (state == VEND) && so_q;
    assign coin_out_valid = (state == PAYOUT) && pay_any;
    assign coin_out_type  = !coin_out_valid ? 2'b00 :
                            (p5 != 4'd0)    ? 2'b11 :
                            (p2 != 4'd0)    ? 2'b10 : 2'b01;
    assign chg_op1        = sel_q;
    assign chg_op2        = (state == CALC) ? 2'b01 : 2'b00;
    assign chg_i1         = n1;
    assign chg_i2         = n2;
    assign chg_i5         = n5;

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: directed scenarios plus random traffic, every cycle
// compared against a credit/queue-level reference model.
module tb_vend_ctrl;

    localparam int PW = 7;
    localparam int PS = 9;

    logic       clk = 1'b0;
    logic       rst, coin_valid, buy, cancel, coin_out_ready;
    logic [1:0] coin_type, sel;
    logic       coin_reject, buy_fail, busy, water, soda, coin_out_valid;
    logic [3:0] credit;
    logic [1:0] coin_out_type, chg_op1, chg_op2;
    logic [3:0] chg_i1, chg_i2, chg_i5, chg_o1, chg_o2, chg_o5;
    logic       chg_wo, chg_so;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vend_ctrl #(.PRICE_W(PW), .PRICE_S(PS), .CREDIT_MAX(15)) dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_type(coin_type),
        .sel(sel), .buy(buy), .cancel(cancel), .coin_reject(coin_reject),
        .buy_fail(buy_fail), .credit(credit), .busy(busy), .water(water),
        .soda(soda), .coin_out_valid(coin_out_valid), .coin_out_type(coin_out_type),
        .coin_out_ready(coin_out_ready), .chg_op1(chg_op1), .chg_op2(chg_op2),
        .chg_i1(chg_i1), .chg_i2(chg_i2), .chg_i5(chg_i5),
        .chg_o1(chg_o1), .chg_o2(chg_o2), .chg_o5(chg_o5),
        .chg_wo(chg_wo), .chg_so(chg_so)
    );

    // Change datapath stand-in: greedy 5/2/1 split of credit minus price.
    int dp_c;
    always_comb begin
        dp_c   = 0;
        chg_o1 = '0;
        chg_o2 = '0;
        chg_o5 = '0;
        chg_wo = 1'b0;
        chg_so = 1'b0;
        if (chg_op2 == 2'b01) begin
            dp_c = int'(chg_i1) + 2 * int'(chg_i2) + 5 * int'(chg_i5)
                   - ((chg_op1 == 2'b01) ? PW : PS);
            if (dp_c < 0) dp_c = 0;
            chg_o5 = 4'(dp_c / 5);
            chg_o2 = 4'((dp_c % 5) / 2);
            chg_o1 = 4'((dp_c % 5) % 2);
            chg_wo = (chg_op1 == 2'b01);
            chg_so = (chg_op1 == 2'b10);
        end
    end

    // Reference model: phase 0 idle, 1 evaluating, 2 dispensing, 3 paying out.
    int m_n1, m_n2, m_n5, m_phase, m_sel;
    int m_q[$];
    bit m_rej, m_fail;

    function automatic int m_credit();
        return m_n1 + 2 * m_n2 + 5 * m_n5;
    endfunction

    function automatic int coin_value(input logic [1:0] t);
        return (t == 2'b01) ? 1 : (t == 2'b10) ? 2 : (t == 2'b11) ? 5 : 0;
    endfunction

    task automatic push_coins(input int c5, input int c2, input int c1);
        for (int i = 0; i < c5; i++) m_q.push_back(3);
        for (int i = 0; i < c2; i++) m_q.push_back(2);
        for (int i = 0; i < c1; i++) m_q.push_back(1);
    endtask

    task automatic model_reset();
        m_n1 = 0; m_n2 = 0; m_n5 = 0; m_phase = 0; m_sel = 0;
        m_q.delete();
        m_rej = 0; m_fail = 0;
    endtask

    task automatic model_step();
        int cr, v, price, chg;
        if (rst) begin
            model_reset();
            return;
        end
        cr = m_credit();
        m_rej = 0;
        m_fail = 0;
        case (m_phase)
            0: begin
                if (cancel) begin
                    m_rej = coin_valid;
                    if (cr > 0) begin
                        push_coins(m_n5, m_n2, m_n1);
                        m_n1 = 0; m_n2 = 0; m_n5 = 0;
                        m_phase = 3;
                    end
                end else if (buy) begin
                    m_rej = coin_valid;
                    price = (sel == 2'b01) ? PW : PS;
                    if (!(sel == 2'b01 || sel == 2'b10) || cr < price) m_fail = 1;
                    else begin
                        m_sel = int'(sel);
                        m_phase = 1;
                    end
                end else if (coin_valid) begin
                    v = coin_value(coin_type);
                    if (v == 0 || cr + v > 15) m_rej = 1;
                    else if (v == 1) m_n1++;
                    else if (v == 2) m_n2++;
                    else m_n5++;
                end
            end
            1: begin
                m_rej = coin_valid;
                chg = cr - ((m_sel == 1) ? PW : PS);
                push_coins(chg / 5, (chg % 5) / 2, (chg % 5) % 2);
                m_n1 = 0; m_n2 = 0; m_n5 = 0;
                m_phase = 2;
            end
            2: begin
                m_rej = coin_valid;
                m_phase = 3;
            end
            default: begin
                m_rej = coin_valid;
                if (m_q.size() == 0) begin
                    m_phase = 0; m_sel = 0;
                end else if (coin_out_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        m_phase = 0; m_sel = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic compare();
        bit exp_valid;
        exp_valid = (m_phase == 3) && (m_q.size() > 0);
        chk("credit", 32'(credit), 32'(m_credit()));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("water", 32'(water), 32'(m_phase == 2 && m_sel == 1));
        chk("soda", 32'(soda), 32'(m_phase == 2 && m_sel == 2));
        chk("coin_reject", 32'(coin_reject), 32'(m_rej));
        chk("buy_fail", 32'(buy_fail), 32'(m_fail));
        chk("coin_out_valid", 32'(coin_out_valid), 32'(exp_valid));
        if (exp_valid) chk("coin_out_type", 32'(coin_out_type), 32'(m_q[0]));
        chk("chg_op1", 32'(chg_op1), 32'(m_sel));
        chk("chg_op2", 32'(chg_op2), 32'(m_phase == 1));
        chk("chg_i1", 32'(chg_i1), 32'(m_n1));
        chk("chg_i2", 32'(chg_i2), 32'(m_n2));
        chk("chg_i5", 32'(chg_i5), 32'(m_n5));
    endtask

    task automatic step(input logic cv, input logic [1:0] ct, input logic [1:0] s,
                        input logic b, input logic c, input logic r, input logic rs);
        coin_valid = cv; coin_type = ct; sel = s; buy = b; cancel = c;
        coin_out_ready = r; rst = rs;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic coin(input logic [1:0] t);
        step(1'b1, t, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, r, 1'b0);
    endtask

    task automatic purchase(input logic [1:0] s);
        step(1'b0, 2'b00, s, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b1);

        // Water with one unit change
        coin(2'b11); coin(2'b10); coin(2'b01);
        purchase(2'b01);
        idle(5, 1'b1);

        // Soda with stalled payout
        coin(2'b11); coin(2'b11);
        purchase(2'b10);
        idle(5, 1'b0);
        idle(3, 1'b1);

        // Refused purchases
        coin(2'b11);
        purchase(2'b10);
        coin(2'b11);
        purchase(2'b11);
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Credit ceiling and invalid coin
        coin(2'b11); coin(2'b11); coin(2'b11);
        coin(2'b01);
        coin(2'b00);
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(5, 1'b1);

        // Refund with a coin offered mid-payout
        coin(2'b11); coin(2'b10); coin(2'b10);
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        coin(2'b01);
        idle(4, 1'b1);

        // Reset during payout, then a normal purchase
        coin(2'b11); coin(2'b11); coin(2'b10);
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1, 1'b1);
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        coin(2'b11); coin(2'b10); coin(2'b01);
        purchase(2'b01);
        idle(5, 1'b1);

        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 9) < 5, 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 399) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
